// File: rtl/chip8_mem_pkg.sv
// chip8_mem_pkg: owner encodings and memory-map constants shared by the CHIP-8
// CPU, PPU, video scanout and the RAM arbiter.
`default_nettype none

package chip8_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_PPU  = 2'd2,
        OWN_VID  = 2'd3
    } owner_t;

    localparam logic [11:0] FONT_BASE = 12'h000;
    localparam logic [11:0] FB_BASE   = 12'h100;
    localparam int unsigned FB_SIZE   = 256;
    localparam logic [11:0] PROG_BASE = 12'h200;

    localparam logic RR_CPU = 1'b0;
    localparam logic RR_PPU = 1'b1;

    // Inclusive lower bound, exclusive upper bound.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr >= base) && (addr < (base + size));
    endfunction

endpackage

`default_nettype wire

// File: rtl/chip8_rr_pick2.sv
// chip8_rr_pick2: two-way round-robin picker. Bit 0 is the CPU, bit 1 the PPU;
// i_ptr names the preferred requester when both ask.
`default_nettype none

module chip8_rr_pick2
    import chip8_mem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt,
    output logic       o_next_ptr
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_ptr == RR_PPU) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    always_comb begin
        o_next_ptr = i_ptr;
        if (o_gnt[0]) begin
            o_next_ptr = RR_PPU;
        end else if (o_gnt[1]) begin
            o_next_ptr = RR_CPU;
        end
    end

endmodule

`default_nettype wire

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: single-port CHIP-8 RAM arbiter for CPU, PPU and video.
// Video wins in bounded bursts; CPU and PPU alternate round-robin.
`default_nettype none

module chip8_mem_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int                ADDR_W        = 12,
    parameter int                DATA_W        = 8,
    parameter int                VID_MAX_BURST = 8,
    parameter logic [ADDR_W-1:0] FB_BASE       = ADDR_W'(chip8_mem_pkg::FB_BASE)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,

    input  logic              i_ppu_req,
    input  logic              i_ppu_we,
    input  logic [ADDR_W-1:0] i_ppu_addr,
    input  logic [DATA_W-1:0] i_ppu_wdata,
    output logic              o_ppu_gnt,
    output logic              o_ppu_rvalid,
    output logic [DATA_W-1:0] o_ppu_rdata,

    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_gnt,
    output logic              o_vid_rvalid,
    output logic [DATA_W-1:0] o_vid_rdata,

    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,

    output logic              o_fb_err
);

    logic              r_run;
    owner_t            r_pend;
    logic              r_rr_ptr;
    logic [3:0]        r_burst_cnt;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_fb_err;

    logic              w_cp_any;
    logic              w_burst_full;
    logic              w_vid_gnt;
    logic [1:0]        w_pick_req;
    logic [1:0]        w_pick_gnt;
    logic              w_next_ptr;
    logic              w_cpu_gnt;
    logic              w_ppu_gnt;
    logic              w_fb_hit;
    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    owner_t            w_read_owner;

    assign w_cp_any     = i_cpu_req | i_ppu_req;
    assign w_burst_full = (r_burst_cnt == 4'(VID_MAX_BURST));

    // r_run holds off all grants until the first clock after reset release.
    assign w_vid_gnt  = r_run & i_vid_req & ~(w_burst_full & w_cp_any);
    assign w_pick_req = {i_ppu_req, i_cpu_req} & {2{r_run & ~w_vid_gnt}};

    chip8_rr_pick2 u_pick (
        .i_req      (w_pick_req),
        .i_ptr      (r_rr_ptr),
        .o_gnt      (w_pick_gnt),
        .o_next_ptr (w_next_ptr)
    );

    assign w_cpu_gnt = w_pick_gnt[0];
    assign w_ppu_gnt = w_pick_gnt[1];
    assign w_fb_hit  = in_window(32'(i_ppu_addr), 32'(FB_BASE), FB_SIZE);

    always_comb begin
        w_addr       = r_ram_addr;
        w_we         = 1'b0;
        w_wdata      = '0;
        w_read_owner = OWN_NONE;
        if (w_vid_gnt) begin
            w_addr       = i_vid_addr;
            w_read_owner = OWN_VID;
        end else if (w_cpu_gnt) begin
            w_addr       = i_cpu_addr;
            w_we         = i_cpu_we;
            w_wdata      = i_cpu_wdata;
            w_read_owner = i_cpu_we ? OWN_NONE : OWN_CPU;
        end else if (w_ppu_gnt) begin
            w_addr       = i_ppu_addr;
            w_we         = i_ppu_we & w_fb_hit;
            w_wdata      = i_ppu_wdata;
            w_read_owner = i_ppu_we ? OWN_NONE : OWN_PPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_pend      <= OWN_NONE;
            r_rr_ptr    <= RR_CPU;
            r_burst_cnt <= 4'd0;
            r_ram_addr  <= '0;
            r_fb_err    <= 1'b0;
        end else begin
            r_run    <= 1'b1;
            r_pend   <= w_read_owner;
            r_rr_ptr <= w_next_ptr;
            if (w_vid_gnt | w_cpu_gnt | w_ppu_gnt) begin
                r_ram_addr <= w_addr;
            end
            if (w_cpu_gnt | w_ppu_gnt | ~w_cp_any) begin
                r_burst_cnt <= 4'd0;
            end else if (w_vid_gnt && !w_burst_full) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
            end
            if (w_ppu_gnt & i_ppu_we & ~w_fb_hit) begin
                r_fb_err <= 1'b1;
            end
        end
    end

    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_ppu_gnt    = w_ppu_gnt;
    assign o_vid_gnt    = w_vid_gnt;
    assign o_cpu_rvalid = (r_pend == OWN_CPU);
    assign o_ppu_rvalid = (r_pend == OWN_PPU);
    assign o_vid_rvalid = (r_pend == OWN_VID);
    assign o_cpu_rdata  = i_ram_rdata;
    assign o_ppu_rdata  = i_ram_rdata;
    assign o_vid_rdata  = i_ram_rdata;
    assign o_ram_addr   = w_addr;
    assign o_ram_we     = w_we;
    assign o_ram_wdata  = w_wdata;
    assign o_fb_err     = r_fb_err;

endmodule

`default_nettype wire

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: directed stimulus with a grant/read-data scoreboard
// checked by an independent monitor on the falling clock edge.
`default_nettype none

module tb_chip8_mem_arbiter;

    localparam int CPU = 1;
    localparam int PPU = 2;
    localparam int VID = 3;

    typedef struct {
        int         own;
        logic [7:0] data;
    } rv_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, ppu_req, ppu_we, vid_req;
    logic [11:0] cpu_addr, ppu_addr, vid_addr;
    logic [7:0]  cpu_wdata, ppu_wdata;
    logic        cpu_gnt, cpu_rvalid, ppu_gnt, ppu_rvalid, vid_gnt, vid_rvalid;
    logic [7:0]  cpu_rdata, ppu_rdata, vid_rdata;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        fb_err;

    int  n_chk  = 0;
    int  n_pass = 0;
    int  exp_gnt[$];
    rv_t exp_rv[$];

    logic [7:0] mem [4096];
    logic       mem_init = 1'b0;

    always #5 clk = ~clk;

    chip8_mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_gnt    (cpu_gnt),
        .o_cpu_rvalid (cpu_rvalid),
        .o_cpu_rdata  (cpu_rdata),
        .i_ppu_req    (ppu_req),
        .i_ppu_we     (ppu_we),
        .i_ppu_addr   (ppu_addr),
        .i_ppu_wdata  (ppu_wdata),
        .o_ppu_gnt    (ppu_gnt),
        .o_ppu_rvalid (ppu_rvalid),
        .o_ppu_rdata  (ppu_rdata),
        .i_vid_req    (vid_req),
        .i_vid_addr   (vid_addr),
        .o_vid_gnt    (vid_gnt),
        .o_vid_rvalid (vid_rvalid),
        .o_vid_rdata  (vid_rdata),
        .o_ram_addr   (ram_addr),
        .o_ram_we     (ram_we),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata),
        .o_fb_err     (fb_err)
    );

    // Registered single-port RAM with preloaded contents.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h000] <= 8'hF0;
            mem[12'h100] <= 8'h5A;
            mem[12'h200] <= 8'h12;
            mem[12'h201] <= 8'h34;
            mem[12'h202] <= 8'h56;
            mem[12'h300] <= 8'h55;
            mem_init     <= 1'b1;
            ram_rdata    <= 8'h00;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        int   ng, nr, own;
        rv_t  e;
        logic [7:0] d;
        ng = int'(cpu_gnt) + int'(ppu_gnt) + int'(vid_gnt);
        nr = int'(cpu_rvalid) + int'(ppu_rvalid) + int'(vid_rvalid);
        if (ng > 1) check("gnt_onehot", ng, 1);
        if (ng != 0) begin
            own = vid_gnt ? VID : (cpu_gnt ? CPU : PPU);
            if (exp_gnt.size() == 0) check("gnt_unexpected", own, 0);
            else check("gnt_owner", own, exp_gnt.pop_front());
        end
        if (nr > 1) check("rvalid_onehot", nr, 1);
        if (nr != 0) begin
            own = vid_rvalid ? VID : (cpu_rvalid ? CPU : PPU);
            d   = vid_rvalid ? vid_rdata : (cpu_rvalid ? cpu_rdata : ppu_rdata);
            if (exp_rv.size() == 0) begin
                check("rvalid_unexpected", own, 0);
            end else begin
                e = exp_rv.pop_front();
                check("rvalid_owner", own, e.own);
                check("rdata", d, e.data);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input int own);
        exp_gnt.push_back(own);
    endtask

    task automatic push_rv(input int own, input logic [7:0] data);
        rv_t e;
        e.own  = own;
        e.data = data;
        exp_rv.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200; cpu_wdata = 8'h00;
        ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 12'h100; ppu_wdata = 8'h00;
        vid_req = 1'b1; vid_addr = 12'h000;

        // Reset held with every requester active.
        repeat (3) tick;
        @(negedge clk);
        check("rst_gnt", {cpu_gnt, ppu_gnt, vid_gnt}, 0);
        check("rst_rvalid", {cpu_rvalid, ppu_rvalid, vid_rvalid}, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_fb_err", fb_err, 0);
        tick;

        push_gnt(VID); push_gnt(CPU); push_gnt(PPU);
        push_rv(VID, 8'hF0); push_rv(CPU, 8'h12); push_rv(PPU, 8'h5A);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_no_gnt", {cpu_gnt, ppu_gnt, vid_gnt}, 0);
        tick;
        tick; vid_req = 1'b0;
        tick; cpu_req = 1'b0;
        tick; ppu_req = 1'b0;
        tick; tick;

        // Lone CPU read: grant now, data one cycle later, address held when idle.
        push_gnt(CPU); push_rv(CPU, 8'h12);
        cpu_addr = 12'h200; cpu_req = 1'b1;
        @(negedge clk);
        check("cpu_rd_gnt", cpu_gnt, 1);
        check("cpu_rd_addr", ram_addr, 12'h200);
        check("cpu_rd_early_rvalid", cpu_rvalid, 0);
        tick; cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_rd_rvalid", cpu_rvalid, 1);
        check("idle_addr_hold", ram_addr, 12'h200);
        check("idle_we", ram_we, 0);
        tick; tick;

        // CPU and PPU both asking: last grant was CPU, so PPU goes first.
        for (int i = 0; i < 8; i++) begin
            push_gnt((i % 2 == 0) ? PPU : CPU);
            push_rv((i % 2 == 0) ? PPU : CPU, (i % 2 == 0) ? 8'h5A : 8'h34);
        end
        cpu_addr = 12'h201; ppu_addr = 12'h100;
        cpu_req = 1'b1; ppu_req = 1'b1;
        repeat (8) tick;
        cpu_req = 1'b0; ppu_req = 1'b0;
        tick; tick;

        // Video burst limit against a waiting CPU.
        for (int i = 0; i < 20; i++) begin
            if (i == 8 || i == 17) begin
                push_gnt(CPU); push_rv(CPU, 8'h34);
            end else begin
                push_gnt(VID); push_rv(VID, 8'h5A);
            end
        end
        vid_addr = 12'h100; cpu_addr = 12'h201;
        vid_req = 1'b1; cpu_req = 1'b1;
        repeat (20) tick;
        vid_req = 1'b0; cpu_req = 1'b0;
        tick; tick;

        // PPU write outside the framebuffer is granted but dropped.
        push_gnt(PPU);
        ppu_addr = 12'h300; ppu_wdata = 8'hAA; ppu_we = 1'b1; ppu_req = 1'b1;
        @(negedge clk);
        check("oob_ppu_gnt", ppu_gnt, 1);
        check("oob_ram_we", ram_we, 0);
        tick; ppu_req = 1'b0; ppu_we = 1'b0;
        @(negedge clk);
        check("oob_fb_err", fb_err, 1);
        tick;
        push_gnt(CPU); push_rv(CPU, 8'h55);
        cpu_addr = 12'h300; cpu_req = 1'b1;
        tick; cpu_req = 1'b0;
        tick; tick;

        push_gnt(PPU);
        ppu_addr = 12'h1F0; ppu_wdata = 8'hAA; ppu_we = 1'b1; ppu_req = 1'b1;
        @(negedge clk);
        check("fb_wr_we", ram_we, 1);
        check("fb_wr_addr", ram_addr, 12'h1F0);
        check("fb_wr_data", ram_wdata, 8'hAA);
        tick; ppu_req = 1'b0; ppu_we = 1'b0;
        tick;
        push_gnt(PPU); push_rv(PPU, 8'hAA);
        ppu_req = 1'b1;
        tick; ppu_req = 1'b0;
        tick; tick;
        check("fb_err_sticky", fb_err, 1);

        // Reset right after a granted read: the read must never complete.
        push_gnt(CPU);
        cpu_addr = 12'h202; cpu_req = 1'b1;
        tick;
        rst_n = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("rst_kill_rvalid", cpu_rvalid, 0);
        check("rst_clr_fb_err", fb_err, 0);
        tick; tick;

        push_gnt(CPU); push_gnt(PPU);
        push_rv(CPU, 8'h12); push_rv(PPU, 8'h5A);
        cpu_addr = 12'h200; ppu_addr = 12'h100;
        cpu_req = 1'b1; ppu_req = 1'b1;
        rst_n = 1'b1;
        tick;
        tick; cpu_req = 1'b0;
        tick; ppu_req = 1'b0;
        repeat (3) tick;

        check("gnt_queue_empty", exp_gnt.size(), 0);
        check("rv_queue_empty", exp_rv.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
